// File: rtl/lfsr_stream_gen_if.sv
// Valid/ready stream carrying assembled LFSR words from the generator to its consumer.
interface lfsr_stream_gen_if #(
    parameter int OUT_WIDTH = 8
);
    logic [OUT_WIDTH-1:0] Rand_out;
    logic                 out_valid;
    logic                 out_ready;

    modport master (output Rand_out, output out_valid, input out_ready);
    modport slave  (input Rand_out, input out_valid, output out_ready);
endinterface

// File: rtl/lfsr_stream_gen.sv
// Parametrised Fibonacci-style LFSR whose shifted-out bits are packed LSB-first into
// OUT_WIDTH-bit words and offered on a stallable valid/ready stream.
module lfsr_stream_gen #(
    parameter int               WIDTH      = 16,
    parameter int               OUT_WIDTH  = 8,
    parameter logic [WIDTH-1:0] TAPS       = 16'h002D,
    parameter logic [WIDTH-1:0] RESET_SEED = 16'hACE1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] Seed,
    input  logic             seed_load,
    input  logic             enable,
    output logic             lockup,
    lfsr_stream_gen_if.master strm
);
    localparam int             CW   = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(OUT_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, FILL, HOLD} fsm_t;

    fsm_t                 fsm_reg, fsm_next;
    logic [WIDTH-1:0]     state_reg;
    logic [CW-1:0]        cnt_reg;
    logic [OUT_WIDTH-1:0] word_reg;
    logic [OUT_WIDTH-1:0] word_next;
    logic [OUT_WIDTH-1:0] rand_reg;
    logic                 lockup_reg;
    logic                 fb;
    logic                 shift;
    logic                 last_bit;

    assign fb       = ^(state_reg & TAPS);
    assign last_bit = (cnt_reg == LAST);

    // The oldest emitted bit drifts down to the LSB as later bits enter at the top.
    generate
        if (OUT_WIDTH == 1) begin : g_word_single
            assign word_next = state_reg[0];
        end else begin : g_word_multi
            assign word_next = {state_reg[0], word_reg[OUT_WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fsm_reg <= IDLE;
        end else begin
            fsm_reg <= fsm_next;
        end
    end

    always_comb begin
        fsm_next = fsm_reg;
        shift    = 1'b0;
        case (fsm_reg)
            IDLE: begin
                if (enable) begin
                    fsm_next = FILL;
                end
            end
            FILL: begin
                if (enable) begin
                    shift = 1'b1;
                    if (last_bit) begin
                        fsm_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (strm.out_ready) begin
                    fsm_next = enable ? FILL : IDLE;
                end
            end
            default: fsm_next = IDLE;
        endcase
        // A seed load aborts whatever is in flight, including a transfer on the same edge.
        if (seed_load) begin
            fsm_next = IDLE;
            shift    = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg  <= RESET_SEED;
            cnt_reg    <= '0;
            word_reg   <= '0;
            rand_reg   <= '0;
            lockup_reg <= 1'b0;
        end else if (seed_load) begin
            // All-zero is a fixed point of the LFSR, so a zero seed is replaced by 1.
            state_reg  <= (Seed == '0) ? WIDTH'(1) : Seed;
            cnt_reg    <= '0;
            word_reg   <= '0;
            lockup_reg <= (Seed == '0);
        end else if (shift) begin
            state_reg <= {fb, state_reg[WIDTH-1:1]};
            word_reg  <= word_next;
            if (last_bit) begin
                cnt_reg  <= '0;
                rand_reg <= word_next;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign strm.Rand_out  = rand_reg;
    assign strm.out_valid = (fsm_reg == HOLD);
    assign lockup         = lockup_reg;
endmodule

// File: tb/tb_lfsr_stream_gen.sv
// Self-checking bench: a 4-bit instance driven through directed/table phases with a word
// scoreboard, and a default-parameter instance free-running against a reference LFSR.
module tb_lfsr_stream_gen;
    logic        CLK = 1'b0;
    logic        RST;
    logic        rst16;
    logic [3:0]  seed4;
    logic        load4;
    logic        en4;
    logic        lock4;
    logic [15:0] seed16;
    logic        load16;
    logic        en16;
    logic        lock16;

    always #5 CLK = ~CLK;

    lfsr_stream_gen_if #(.OUT_WIDTH(4)) s4 ();
    lfsr_stream_gen_if #(.OUT_WIDTH(8)) s16 ();

    lfsr_stream_gen #(
        .WIDTH(4), .OUT_WIDTH(4), .TAPS(4'b0011), .RESET_SEED(4'b0001)
    ) dut4 (
        .CLK(CLK), .RST(RST), .Seed(seed4), .seed_load(load4),
        .enable(en4), .lockup(lock4), .strm(s4)
    );

    lfsr_stream_gen dut16 (
        .CLK(CLK), .RST(rst16), .Seed(seed16), .seed_load(load16),
        .enable(en16), .lockup(lock16), .strm(s16)
    );

    typedef struct {
        logic [3:0] seed;
        logic       lock;
        logic [3:0] w0;
        logic [3:0] w1;
    } vec_t;

    vec_t        vecs [4];
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  exp_q [$];
    logic [3:0]  cap_q [$];
    logic [3:0]  m4;
    logic [15:0] m16 = 16'hACE1;
    int          w16 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] step4(input logic [3:0] s);
        return {^(s & 4'b0011), s[3:1]};
    endfunction

    task automatic push4(input int n);
        logic [3:0] w;
        for (int i = 0; i < n; i++) begin
            w = '0;
            repeat (4) begin
                w  = {m4[0], w[3:1]};
                m4 = step4(m4);
            end
            exp_q.push_back(w);
        end
    endtask

    // Samples both streams between edges, then advances to just after the next rising edge.
    task automatic tick();
        logic [3:0] e;
        logic [7:0] w8;
        @(negedge CLK);
        if (RST && s4.out_valid && s4.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL word4 actual=%h required=none", s4.Rand_out);
            end else begin
                e = exp_q.pop_front();
                if (s4.Rand_out !== e) begin
                    errors++;
                    $display("FAIL word4 actual=%h required=%h", s4.Rand_out, e);
                end else begin
                    $display("word4 %h", s4.Rand_out);
                end
            end
            cap_q.push_back(s4.Rand_out);
        end
        if (rst16 && s16.out_valid) begin
            w8 = '0;
            repeat (8) begin
                w8  = {m16[0], w8[7:1]};
                m16 = {^(m16 & 16'h002D), m16[15:1]};
            end
            checks++;
            if (s16.Rand_out !== w8) begin
                errors++;
                $display("FAIL word16 actual=%h required=%h", s16.Rand_out, w8);
            end else begin
                $display("word16 %h", s16.Rand_out);
            end
            w16++;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_valid4(input int max, output int n);
        n = 0;
        while (!s4.out_valid && n < max) begin
            tick();
            n++;
        end
        if (!s4.out_valid) check("valid_timeout", 0, 1);
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            tick();
            n++;
        end
        check("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic load_seed(input logic [3:0] s);
        seed4 = s;
        load4 = 1'b1;
        en4   = 1'b0;
        tick();
        load4 = 1'b0;
    endtask

    initial begin
        int n;
        int m;
        int bad;
        int early;
        vecs[0] = '{4'h0, 1'b1, 4'b0001, 4'b1001};
        vecs[1] = '{4'h5, 1'b0, 4'b0101, 4'b1111};
        vecs[2] = '{4'h1, 1'b0, 4'b0001, 4'b1001};
        vecs[3] = '{4'h8, 1'b0, 4'b1000, 4'b1100};

        RST = 1'b0; rst16 = 1'b0;
        seed4 = '0; load4 = 1'b0; en4 = 1'b0; s4.out_ready = 1'b0;
        seed16 = '0; load16 = 1'b0; en16 = 1'b1; s16.out_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_rand", s4.Rand_out, 4'h0);
        check("rst_valid", s4.out_valid, 1'b0);
        check("rst_lockup", lock4, 1'b0);
        RST = 1'b1; rst16 = 1'b1;

        // Word sequence from RESET_SEED with latency and throughput
        exp_q.push_back(4'b0001); exp_q.push_back(4'b1001); exp_q.push_back(4'b0101);
        en4 = 1'b1; s4.out_ready = 1'b1;
        wait_valid4(20, n);
        check("latency", n, 5);
        for (int k = 0; k < 2; k++) begin
            tick();
            wait_valid4(20, n);
            check("throughput", n + 1, 5);
        end
        tick();
        en4 = 1'b0;
        check("seq_done", exp_q.size(), 0);

        // Seed table: lockup flag and first two words after each load
        for (int i = 0; i < 4; i++) begin
            load_seed(vecs[i].seed);
            check("tbl_lockup", lock4, vecs[i].lock);
            check("tbl_valid", s4.out_valid, 1'b0);
            exp_q.push_back(vecs[i].w0);
            exp_q.push_back(vecs[i].w1);
            en4 = 1'b1;
            drain(40);
            en4 = 1'b0;
        end

        // Back-pressure: 10 stalled cycles in HOLD
        load_seed(4'h1);
        s4.out_ready = 1'b0;
        exp_q.push_back(4'b0001); exp_q.push_back(4'b1001);
        en4 = 1'b1;
        wait_valid4(20, n);
        check("bp_latency", n, 5);
        bad = 0;
        repeat (10) begin
            tick();
            if (s4.Rand_out !== 4'b0001 || s4.out_valid !== 1'b1) bad++;
        end
        check("bp_stable", bad, 0);
        s4.out_ready = 1'b1;
        drain(40);
        en4 = 1'b0;

        // Pause 3 cycles mid-FILL
        load_seed(4'h1);
        exp_q.push_back(4'b0001);
        en4 = 1'b1;
        repeat (3) tick();
        en4 = 1'b0;
        repeat (3) tick();
        en4 = 1'b1;
        wait_valid4(20, m);
        check("pause_latency", 6 + m, 8);
        drain(20);
        en4 = 1'b0;

        // Abort a partial word with seed_load
        load_seed(4'h1);
        en4 = 1'b1;
        repeat (3) tick();
        load_seed(4'h5);
        check("abort_valid", s4.out_valid, 1'b0);
        check("abort_rand_kept", s4.Rand_out, 4'b0001);
        check("abort_lockup", lock4, 1'b0);
        bad = 0;
        repeat (6) begin
            tick();
            if (s4.out_valid !== 1'b0) bad++;
        end
        check("abort_idle", bad, 0);
        exp_q.push_back(4'b0101);
        en4 = 1'b1;
        drain(20);
        en4 = 1'b0;

        // seed_load coinciding with a transfer; zero seed substitution
        load_seed(4'h8);
        exp_q.push_back(4'b1000);
        en4 = 1'b1;
        wait_valid4(20, n);
        check("st_latency", n, 5);
        seed4 = 4'h0; load4 = 1'b1;
        tick();
        load4 = 1'b0;
        check("st_valid", s4.out_valid, 1'b0);
        check("st_lockup", lock4, 1'b1);
        check("st_consumed", exp_q.size(), 0);
        exp_q.push_back(4'b0001);
        drain(20);
        en4 = 1'b0;

        // Reset asserted while a word is pending
        s4.out_ready = 1'b0;
        en4 = 1'b1;
        repeat (7) tick();
        check("pre_rst_valid", s4.out_valid, 1'b1);
        RST = 1'b0;
        #1;
        check("mid_rst_rand", s4.Rand_out, 4'h0);
        check("mid_rst_valid", s4.out_valid, 1'b0);
        check("mid_rst_lockup", lock4, 1'b0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        s4.out_ready = 1'b1;
        exp_q.push_back(4'b0001); exp_q.push_back(4'b1001); exp_q.push_back(4'b0101);
        drain(60);
        en4 = 1'b0;

        // Period: 4-bit sequence repeats every 15 words and not sooner
        load_seed(4'h1);
        cap_q.delete();
        m4 = 4'h1;
        push4(30);
        en4 = 1'b1;
        drain(200);
        en4 = 1'b0;
        check("period_count", cap_q.size(), 30);
        if (cap_q.size() >= 30) begin
            bad = 0;
            for (int i = 0; i < 15; i++) if (cap_q[i] !== cap_q[i+15]) bad++;
            check("period_15", bad, 0);
            early = 0;
            for (int p = 1; p < 15; p++) begin
                bad = 0;
                for (int i = 0; i < 15; i++) if (cap_q[i] !== cap_q[i+p]) bad++;
                if (bad == 0) early++;
            end
            check("period_not_early", early, 0);
        end

        // Default-parameter instance: keep running until enough words are compared
        n = 0;
        while (w16 < 120 && n < 2000) begin
            tick();
            n++;
        end
        check("w16_count", (w16 >= 120), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
